// File: rtl/fp_div_pkg.sv
// Shared types and helpers for the iterative floating-point divider.
// Word builders work on a 64-bit container; callers truncate to their word width.
package fp_div_pkg;

  localparam int MAX_W = 64;
  typedef logic [MAX_W-1:0] fp_word_t;

  typedef enum logic [1:0] {IDLE, ITER, NORM, DONE} state_e;
  typedef enum logic [1:0] {CLS_ZERO, CLS_NORMAL, CLS_INF, CLS_NAN} fp_class_e;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_DIV_ZERO  = 2;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_UNDERFLOW = 0;

  function automatic fp_word_t fp_field_mask(input int width);
    return (fp_word_t'(1) << width) - fp_word_t'(1);
  endfunction

  function automatic fp_word_t fp_make_qnan(input int exp_w, input int man_w);
    return (fp_field_mask(exp_w) << man_w) | (fp_word_t'(1) << (man_w - 1));
  endfunction

  function automatic fp_word_t fp_make_inf(input logic sign, input int exp_w, input int man_w);
    return (fp_word_t'(sign) << (exp_w + man_w)) | (fp_field_mask(exp_w) << man_w);
  endfunction

  function automatic fp_word_t fp_make_zero(input logic sign, input int exp_w, input int man_w);
    return fp_word_t'(sign) << (exp_w + man_w);
  endfunction

  // Denormals (exponent 0, fraction nonzero) classify as zero: they are flushed.
  function automatic fp_class_e fp_classify(input fp_word_t word, input int exp_w, input int man_w);
    fp_word_t e_fld;
    fp_word_t f_fld;
    e_fld = (word >> man_w) & fp_field_mask(exp_w);
    f_fld = word & fp_field_mask(man_w);
    if (e_fld == '0) return CLS_ZERO;
    if (e_fld != fp_field_mask(exp_w)) return CLS_NORMAL;
    return (f_fld == '0) ? CLS_INF : CLS_NAN;
  endfunction

endpackage

// File: rtl/fp_div_mant_iter.sv
// Restoring divider for normalised mantissas {1,frac}: one quotient bit per cycle,
// MAN_W+2 bits MSB first (integer bit, then MAN_W+1 fraction bits).
module fp_div_mant_iter #(
  parameter int MAN_W = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MAN_W:0]   dividend,
  input  logic [MAN_W:0]   divisor,
  output logic             busy,
  output logic             done,
  output logic [MAN_W+1:0] quot
);

  localparam int QW    = MAN_W + 2;
  localparam int CNT_W = $clog2(QW + 1);

  logic [MAN_W+1:0] rem_reg;
  logic [MAN_W:0]   div_reg;
  logic [QW-1:0]    quot_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [MAN_W+1:0] div_ext;
  logic [MAN_W+1:0] rem_step;
  logic [MAN_W+1:0] rem_next;
  logic             ge;

  // The remainder stays below the divisor after each step, so the doubled
  // remainder never overflows MAN_W+2 bits.
  always_comb begin
    div_ext  = {1'b0, div_reg};
    ge       = (rem_reg >= div_ext);
    rem_step = ge ? (rem_reg - div_ext) : rem_reg;
    rem_next = {rem_step[MAN_W:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_reg  <= '0;
      div_reg  <= '0;
      quot_reg <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        rem_reg  <= {1'b0, dividend};
        div_reg  <= divisor;
        quot_reg <= '0;
        cnt_reg  <= CNT_W'(QW);
        busy_reg <= 1'b1;
      end else if (busy_reg) begin
        rem_reg  <= rem_next;
        quot_reg <= {quot_reg[QW-2:0], ge};
        cnt_reg  <= cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign quot = quot_reg;

endmodule

// File: rtl/fp_div_iter.sv
// Handshaked iterative floating-point divider / reciprocal unit with IEEE
// special-case handling, truncating rounding and flush-to-zero.
module fp_div_iter
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_val,
  output logic                     in_rdy,
  input  logic                     recip_mode,
  input  logic [EXP_W+MAN_W:0]     num,
  input  logic [EXP_W+MAN_W:0]     den,
  output logic                     out_val,
  input  logic                     out_rdy,
  output logic [EXP_W+MAN_W:0]     quo,
  output logic [3:0]               flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = (2 ** (EXP_W - 1)) - 1;
  localparam int EW   = EXP_W + 2;
  localparam logic signed [EW-1:0] EXP_MAX = EW'((2 ** EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_MIN = EW'(1);
  localparam logic [W-1:0] ONE_WORD = {1'b0, EXP_W'(BIAS), {MAN_W{1'b0}}};

  state_e state_reg, state_next;

  logic                 sign_reg;
  logic signed [EW-1:0] exp_reg;
  logic                 spec_reg;
  logic [W-1:0]         spec_word_reg;
  logic [3:0]           spec_flags_reg;
  logic [W-1:0]         quo_reg;
  logic [3:0]           flags_reg;

  logic                 accept;
  logic [W-1:0]         num_eff;
  fp_class_e            cls_n, cls_d;
  logic                 sign_q;
  logic signed [EW-1:0] exp_base;
  logic                 spec_hit;
  logic [W-1:0]         spec_word;
  logic [3:0]           spec_flags;

  logic                 core_busy;
  logic                 core_done;
  logic [MAN_W+1:0]     core_quot;

  logic                 q_msb;
  logic [MAN_W-1:0]     norm_frac;
  logic signed [EW-1:0] exp_fin;
  logic [W-1:0]         res_word;
  logic [3:0]           res_flags;

  assign accept = in_val && (state_reg == IDLE);

  // Operand decode at accept; special results are decided here and latched.
  always_comb begin
    num_eff    = recip_mode ? ONE_WORD : num;
    cls_n      = fp_classify(fp_word_t'(num_eff), EXP_W, MAN_W);
    cls_d      = fp_classify(fp_word_t'(den), EXP_W, MAN_W);
    sign_q     = num_eff[W-1] ^ den[W-1];
    exp_base   = EW'(num_eff[W-2 -: EXP_W]) - EW'(den[W-2 -: EXP_W]) + EW'(BIAS);
    spec_hit   = 1'b1;
    spec_word  = '0;
    spec_flags = '0;
    if (cls_n == CLS_NAN || cls_d == CLS_NAN ||
        (cls_n == CLS_ZERO && cls_d == CLS_ZERO) ||
        (cls_n == CLS_INF && cls_d == CLS_INF)) begin
      spec_word                = W'(fp_make_qnan(EXP_W, MAN_W));
      spec_flags[FLAG_INVALID] = 1'b1;
    end else if (cls_n == CLS_NORMAL && cls_d == CLS_ZERO) begin
      spec_word                 = W'(fp_make_inf(sign_q, EXP_W, MAN_W));
      spec_flags[FLAG_DIV_ZERO] = 1'b1;
    end else if (cls_n == CLS_INF) begin
      spec_word = W'(fp_make_inf(sign_q, EXP_W, MAN_W));
    end else if (cls_n == CLS_ZERO || cls_d == CLS_INF) begin
      spec_word = W'(fp_make_zero(sign_q, EXP_W, MAN_W));
    end else begin
      spec_hit = 1'b0;
    end
  end

  fp_div_mant_iter #(
    .MAN_W(MAN_W)
  ) u_mant (
    .clk      (clk),
    .rst      (rst),
    .start    (accept),
    .dividend ({1'b1, num_eff[MAN_W-1:0]}),
    .divisor  ({1'b1, den[MAN_W-1:0]}),
    .busy     (core_busy),
    .done     (core_done),
    .quot     (core_quot)
  );

  // Quotient lies in [0.5,2); a clear MSB means one normalising shift.
  always_comb begin
    q_msb     = core_quot[MAN_W+1];
    norm_frac = q_msb ? core_quot[MAN_W:1] : core_quot[MAN_W-1:0];
    exp_fin   = q_msb ? exp_reg : (exp_reg - EW'(1));
    res_word  = {sign_reg, exp_fin[EXP_W-1:0], norm_frac};
    res_flags = '0;
    if (spec_reg) begin
      res_word  = spec_word_reg;
      res_flags = spec_flags_reg;
    end else if (exp_fin >= EXP_MAX) begin
      res_word                 = W'(fp_make_inf(sign_reg, EXP_W, MAN_W));
      res_flags[FLAG_OVERFLOW] = 1'b1;
    end else if (exp_fin < EXP_MIN) begin
      res_word                  = W'(fp_make_zero(sign_reg, EXP_W, MAN_W));
      res_flags[FLAG_UNDERFLOW] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_rdy     = 1'b0;
    out_val    = 1'b0;
    case (state_reg)
      IDLE: begin
        in_rdy = 1'b1;
        if (in_val) state_next = ITER;
      end
      ITER: if (core_done && !core_busy) state_next = NORM;
      NORM: state_next = DONE;
      DONE: begin
        out_val = 1'b1;
        if (out_rdy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sign_reg       <= 1'b0;
      exp_reg        <= '0;
      spec_reg       <= 1'b0;
      spec_word_reg  <= '0;
      spec_flags_reg <= '0;
      quo_reg        <= '0;
      flags_reg      <= '0;
    end else begin
      if (accept) begin
        sign_reg       <= sign_q;
        exp_reg        <= exp_base;
        spec_reg       <= spec_hit;
        spec_word_reg  <= spec_word;
        spec_flags_reg <= spec_flags;
      end
      if (state_reg == NORM) begin
        quo_reg   <= res_word;
        flags_reg <= res_flags;
      end
    end
  end

  assign quo   = quo_reg;
  assign flags = flags_reg;

endmodule

// File: tb/tb_fp_div_iter.sv
// Self-checking bench for fp_div_iter (f32 configuration): vector table through a
// scoreboard, plus hand sequences for backpressure and mid-operation reset.
module tb_fp_div_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_val = 1'b0;
  logic        in_rdy;
  logic        recip_mode = 1'b0;
  logic [31:0] num = '0;
  logic [31:0] den = '0;
  logic        out_val;
  logic        out_rdy = 1'b0;
  logic [31:0] quo;
  logic [3:0]  flags;

  int checks   = 0;
  int failures = 0;

  localparam int LATENCY = 27;

  always #5 clk = ~clk;

  fp_div_iter #(.EXP_W(8), .MAN_W(23)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_val     (in_val),
    .in_rdy     (in_rdy),
    .recip_mode (recip_mode),
    .num        (num),
    .den        (den),
    .out_val    (out_val),
    .out_rdy    (out_rdy),
    .quo        (quo),
    .flags      (flags)
  );

  typedef struct {
    logic        mode;
    logic [31:0] num;
    logic [31:0] den;
    logic [31:0] quo;
    logic [3:0]  flags;
  } vec_t;

  typedef struct {
    logic [31:0] quo;
    logic [3:0]  flags;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // hold > 0: keep out_rdy low that many cycles after out_val; hold < 0: out_rdy high from accept.
  task automatic do_op(input logic mode, input logic [31:0] n, input logic [31:0] d,
                       input logic [31:0] eq, input logic [3:0] ef, input int hold);
    exp_t e;
    int   lat;
    int   w;
    @(negedge clk);
    w = 0;
    while (!in_rdy && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("in_rdy_before_op", 64'(in_rdy), 64'(1));
    recip_mode = mode;
    num        = n;
    den        = d;
    in_val     = 1'b1;
    e.quo      = eq;
    e.flags    = ef;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_val     = 1'b0;
    num        = 32'hDEADBEEF;
    den        = 32'h00000000;
    recip_mode = ~mode;
    if (hold < 0) out_rdy = 1'b1;
    lat = 0;
    while (!out_val && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(LATENCY));
    if (!out_val) begin
      out_rdy = 1'b0;
      void'(sb.pop_front());
      return;
    end
    for (int k = 0; k < hold; k++) begin
      chk("bp_out_val", 64'(out_val), 64'(1));
      chk("bp_in_rdy", 64'(in_rdy), 64'(0));
      chk("bp_quo", 64'(quo), 64'(eq));
      chk("bp_flags", 64'(flags), 64'(ef));
      in_val = 1'b1;
      num    = $urandom;
      den    = $urandom;
      @(posedge clk);
      #1;
    end
    in_val = 1'b0;
    if (sb.size() == 0) begin
      chk("sb_nonempty", 64'(0), 64'(1));
    end else begin
      e = sb.pop_front();
      chk("quo", 64'(quo), 64'(e.quo));
      chk("flags", 64'(flags), 64'(e.flags));
    end
    $display("op mode=%0d num=%08h den=%08h quo=%08h flags=%04b lat=%0d", mode, n, d, quo, flags, lat);
    out_rdy = 1'b1;
    @(posedge clk);
    #1;
    out_rdy = 1'b0;
    chk("in_rdy_after_done", 64'(in_rdy), 64'(1));
    chk("out_val_after_done", 64'(out_val), 64'(0));
  endtask

  initial begin
    int seen;
    vecs.push_back('{1'b0, 32'h40800000, 32'h3F800000, 32'h40800000, 4'b0000});
    vecs.push_back('{1'b0, 32'h3F800000, 32'h40800000, 32'h3E800000, 4'b0000});
    vecs.push_back('{1'b1, 32'h12345678, 32'h40400000, 32'h3EAAAAAA, 4'b0000});
    vecs.push_back('{1'b0, 32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100});
    vecs.push_back('{1'b0, 32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000});
    vecs.push_back('{1'b0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000});
    vecs.push_back('{1'b0, 32'h7F000000, 32'h3F000000, 32'h7F800000, 4'b0010});
    vecs.push_back('{1'b0, 32'h00800000, 32'h40000000, 32'h00000000, 4'b0001});
    vecs.push_back('{1'b0, 32'hC0800000, 32'h3F800000, 32'hC0800000, 4'b0000});
    vecs.push_back('{1'b0, 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000});
    vecs.push_back('{1'b0, 32'h3F800000, 32'h7F800000, 32'h00000000, 4'b0000});
    vecs.push_back('{1'b0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000});
    vecs.push_back('{1'b0, 32'h80400000, 32'h3F800000, 32'h80000000, 4'b0000});
    vecs.push_back('{1'b0, 32'h00000000, 32'hBF800000, 32'h80000000, 4'b0000});
    vecs.push_back('{1'b0, 32'h3FC00000, 32'h3FA00000, 32'h3F999999, 4'b0000});
    vecs.push_back('{1'b0, 32'hC0000000, 32'h40400000, 32'hBF2AAAAA, 4'b0000});
    vecs.push_back('{1'b0, 32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 4'b0000});
    vecs.push_back('{1'b1, 32'h7FC00000, 32'h40000000, 32'h3F000000, 4'b0000});
    vecs.push_back('{1'b1, 32'h3F800000, 32'h80000000, 32'hFF800000, 4'b0100});

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_rdy", 64'(in_rdy), 64'(1));
    chk("rst_out_val", 64'(out_val), 64'(0));
    chk("rst_quo", 64'(quo), 64'(0));
    chk("rst_flags", 64'(flags), 64'(0));
    rst = 1'b1;

    foreach (vecs[i])
      do_op(vecs[i].mode, vecs[i].num, vecs[i].den, vecs[i].quo, vecs[i].flags, 0);

    // out_rdy held high throughout: ignored until DONE
    do_op(1'b0, 32'h40C00000, 32'h3FC00000, 32'h40800000, 4'b0000, -1);

    // Backpressure with ignored in_val pulses
    do_op(1'b0, 32'h40800000, 32'h3F800000, 32'h40800000, 4'b0000, 5);

    // Asynchronous reset mid-ITER discards the operation
    @(negedge clk);
    recip_mode = 1'b0;
    num        = 32'h3F800000;
    den        = 32'h40400000;
    in_val     = 1'b1;
    @(posedge clk);
    #1;
    in_val = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("midrst_out_val", 64'(out_val), 64'(0));
    chk("midrst_in_rdy", 64'(in_rdy), 64'(1));
    chk("midrst_quo", 64'(quo), 64'(0));
    chk("midrst_flags", 64'(flags), 64'(0));
    repeat (2) @(negedge clk);
    rst  = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_val) seen++;
    end
    chk("midrst_no_result", 64'(seen), 64'(0));

    do_op(1'b0, 32'h3F800000, 32'h40800000, 32'h3E800000, 4'b0000, 0);
    do_op(1'b1, 32'h00000000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, 0);

    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
